// File: rtl/xcore_if_bpu.sv
// Fetch-stage branch predictor: 2-bit BHT counters plus a tagged BTB.
// The prediction is registered, one cycle after the request.
module xcore_if_bpu #(
  parameter int BHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int BTB_TAG_W = 30 - BTB_IDX_W
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_pc,
  input  logic        i_if_stall,
  input  logic        i_flush,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  output logic        o_bp_valid,
  output logic [31:0] o_bp_pc,
  output logic [1:0]  o_bp_deci,
  output logic        o_bp_taken,
  output logic [31:0] o_bp_target
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;

  // Output handshake: o_bp_valid is a plain valid qualifier with no ready.
  // The consumer pauses it with i_if_stall (all outputs hold) and drops it
  // with i_flush; the other outputs are meaningful only while it is high.

  logic [1:0]           bht       [BHT_N];
  logic                 btb_valid [BTB_N];
  logic [BTB_TAG_W-1:0] btb_tag   [BTB_N];
  logic [31:0]          btb_tgt   [BTB_N];

  logic [BHT_IDX_W-1:0] rd_bht_idx;
  logic [BTB_IDX_W-1:0] rd_btb_idx;
  logic [BHT_IDX_W-1:0] wr_bht_idx;
  logic [BTB_IDX_W-1:0] wr_btb_idx;
  logic [1:0]           rd_ctr;
  logic [1:0]           wr_ctr;
  logic                 rd_hit;
  logic                 pred_taken;
  logic [1:0]           pred_deci;
  logic [31:0]          pred_target;
  logic                 unused_pc_lsbs;

  assign unused_pc_lsbs = ^{i_if_pc[1:0], i_upd_pc[1:0]};

  assign rd_bht_idx = i_if_pc[BHT_IDX_W+1:2];
  assign rd_btb_idx = i_if_pc[BTB_IDX_W+1:2];
  assign wr_bht_idx = i_upd_pc[BHT_IDX_W+1:2];
  assign wr_btb_idx = i_upd_pc[BTB_IDX_W+1:2];

  // Reads use pre-edge table contents, so a same-cycle update is not seen.
  always_comb begin
    rd_ctr      = bht[rd_bht_idx];
    rd_hit      = btb_valid[rd_btb_idx] &&
                  (btb_tag[rd_btb_idx] == i_if_pc[31:BTB_IDX_W+2]);
    pred_taken  = rd_ctr[1] && rd_hit;
    pred_deci   = pred_taken ? rd_ctr : 2'b00;
    pred_target = pred_taken ? btb_tgt[rd_btb_idx] : (i_if_pc + 32'd4);
  end

  always_comb begin
    wr_ctr = bht[wr_bht_idx];
    if (i_upd_taken) begin
      if (wr_ctr != 2'b11) wr_ctr = wr_ctr + 2'b01;
    end else begin
      if (wr_ctr != 2'b00) wr_ctr = wr_ctr - 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (i_upd_valid) begin
      bht[wr_bht_idx] <= wr_ctr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
    end else if (i_upd_valid && i_upd_taken) begin
      btb_valid[wr_btb_idx] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset; the valid bit gates their use.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_upd_valid && i_upd_taken) begin
      btb_tag[wr_btb_idx] <= i_upd_pc[31:BTB_IDX_W+2];
      btb_tgt[wr_btb_idx] <= i_upd_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bp_valid  <= 1'b0;
      o_bp_pc     <= '0;
      o_bp_deci   <= 2'b00;
      o_bp_taken  <= 1'b0;
      o_bp_target <= '0;
    end else if (i_flush) begin
      o_bp_valid  <= 1'b0;
    end else if (i_if_stall) begin
      o_bp_valid  <= o_bp_valid;
    end else if (i_if_req) begin
      o_bp_valid  <= 1'b1;
      o_bp_pc     <= i_if_pc;
      o_bp_deci   <= pred_deci;
      o_bp_taken  <= pred_taken;
      o_bp_target <= pred_target;
    end else begin
      o_bp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xcore_if_bpu.sv
// Self-checking bench for xcore_if_bpu: directed plan with literal checks,
// then randomized traffic compared every cycle against a behavioural model.
module tb_xcore_if_bpu;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        bp_valid;
  logic [31:0] bp_pc;
  logic [1:0]  bp_deci;
  logic        bp_taken;
  logic [31:0] bp_target;

  int tests = 0;
  int fails = 0;

  // packed expectation: {valid, pc, deci, taken, target}
  logic [67:0] exp_q[$];

  // behavioural model: counters as integers 0..3, BTB keeps the full PC
  int          m_ctr [64];
  bit          m_bv  [16];
  logic [31:0] m_bpc [16];
  logic [31:0] m_btgt[16];
  logic        e_valid;
  logic [31:0] e_pc;
  logic [1:0]  e_deci;
  logic        e_taken;
  logic [31:0] e_target;

  xcore_if_bpu dut (
    .i_clk(clk), .i_rst(rst), .i_if_req(if_req), .i_if_pc(if_pc),
    .i_if_stall(if_stall), .i_flush(flush), .i_upd_valid(upd_valid),
    .i_upd_pc(upd_pc), .i_upd_taken(upd_taken), .i_upd_target(upd_target),
    .o_bp_valid(bp_valid), .o_bp_pc(bp_pc), .o_bp_deci(bp_deci),
    .o_bp_taken(bp_taken), .o_bp_target(bp_target)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 0; if_req = 0; if_pc = 0; if_stall = 0; flush = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
  endtask

  // model: what the outputs must be after the coming edge
  task automatic model_edge();
    int bi, ti, c;
    bit hit, tk;
    bi  = int'((if_pc >> 2) % 64);
    ti  = int'((if_pc >> 2) % 16);
    c   = m_ctr[bi];
    hit = m_bv[ti] && ((m_bpc[ti] >> 6) == (if_pc >> 6));
    tk  = (c >= 2) && hit;
    if (rst) begin
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      for (int i = 0; i < 16; i++) m_bv[i] = 0;
      e_valid = 0; e_pc = 0; e_deci = 0; e_taken = 0; e_target = 0;
    end else begin
      if (flush) e_valid = 0;
      else if (if_stall) e_valid = e_valid;
      else if (if_req) begin
        e_valid  = 1;
        e_pc     = if_pc;
        e_taken  = tk;
        e_deci   = tk ? 2'(c) : 2'b00;
        e_target = tk ? m_btgt[ti] : if_pc + 32'd4;
      end else e_valid = 0;
      if (upd_valid) begin
        bi = int'((upd_pc >> 2) % 64);
        ti = int'((upd_pc >> 2) % 16);
        if (upd_taken) begin
          m_ctr[bi] = (m_ctr[bi] < 3) ? m_ctr[bi] + 1 : 3;
          m_bv[ti]   = 1;
          m_bpc[ti]  = upd_pc;
          m_btgt[ti] = upd_target;
        end else begin
          m_ctr[bi] = (m_ctr[bi] > 0) ? m_ctr[bi] - 1 : 0;
        end
      end
    end
    exp_q.push_back({e_valid, e_pc, e_deci, e_taken, e_target});
  endtask

  // one cycle: model, edge, compare against the queued expectation
  task automatic step();
    logic [67:0] e;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("valid", 32'(bp_valid), 32'(e[67]));
    if (e[67]) begin
      chk("pc", bp_pc, e[66:35]);
      chk("deci", 32'(bp_deci), 32'(e[34:33]));
      chk("taken", 32'(bp_taken), 32'(e[32]));
      chk("target", bp_target, e[31:0]);
    end
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); idle();
  endtask

  task automatic lookup(input logic [31:0] pc);
    idle(); if_req = 1; if_pc = pc; step(); idle();
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    idle(); upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt; step(); idle();
  endtask

  task automatic lit(input string n, input logic v, input logic [1:0] d,
                     input logic t, input logic [31:0] tgt);
    chk({n, "_valid"}, 32'(bp_valid), 32'(v));
    chk({n, "_deci"}, 32'(bp_deci), 32'(d));
    chk({n, "_taken"}, 32'(bp_taken), 32'(t));
    chk({n, "_target"}, bp_target, tgt);
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
         | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] held_tgt;
    idle();
    e_valid = 0; e_pc = 0; e_deci = 0; e_taken = 0; e_target = 0;
    repeat (2) @(posedge clk);
    #1;

    do_reset();
    lit("reset", 0, 2'b00, 0, 32'h0);
    chk("reset_pc", bp_pc, 32'h0);

    lookup(32'h100);
    lit("cold", 1, 2'b00, 0, 32'h104);

    repeat (3) train(32'h100, 1, 32'h80);
    lookup(32'h100);
    lit("trained", 1, 2'b11, 1, 32'h80);
    train(32'h100, 1, 32'h80);
    lookup(32'h100);
    lit("saturate", 1, 2'b11, 1, 32'h80);

    lookup(32'h200);
    lit("alias", 1, 2'b00, 0, 32'h204);

    do_reset();
    idle(); if_req = 1; if_pc = 32'h100;
    upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h80;
    step(); idle();
    lit("same_cycle", 1, 2'b00, 0, 32'h104);
    lookup(32'h100);
    lit("after_same", 1, 2'b10, 1, 32'h80);
    held_tgt = bp_target;

    idle(); if_stall = 1; if_req = 1; if_pc = 32'h300;
    step();
    lit("stall1", 1, 2'b10, 1, held_tgt);
    step();
    lit("stall2", 1, 2'b10, 1, held_tgt);
    chk("stall_pc", bp_pc, 32'h100);
    flush = 1;
    step(); idle();
    chk("flush_valid", 32'(bp_valid), 32'h0);

    do_reset();
    lookup(32'hFFFF_FFFC);
    lit("wrap", 1, 2'b00, 0, 32'h0);
    repeat (3) train(32'h40, 1, 32'h1000);
    lookup(32'h40);
    lit("pre_rst", 1, 2'b11, 1, 32'h1000);
    do_reset();
    lookup(32'h40);
    lit("post_rst", 1, 2'b00, 0, 32'h44);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      if_stall   = ($urandom_range(0, 6) == 0);
      if_req     = ($urandom_range(0, 9) < 7);
      if_pc      = rnd_pc();
      upd_valid  = ($urandom_range(0, 1) == 1);
      upd_pc     = rnd_pc();
      upd_taken  = ($urandom_range(0, 2) != 0);
      upd_target = $urandom() & 32'hFFFF_FFFC;
      step();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xcore_if_bpu.md
Name: xcore_if_bpu

Overview:
- Fetch-stage branch prediction unit. It produces the 2-bit decision that travels down the pipeline with each instruction and is consumed by the mem-stage BJP unit.
- Contains a direct-mapped branch history table (BHT) of 2-bit saturating counters and a direct-mapped branch target buffer (BTB).
- Lookup is registered, with 1-cycle latency. The resolved outcome from the BJP stage trains both tables.

Parameters:
- BHT_IDX_W, 6, log2 of BHT entries (64); index = pc[BHT_IDX_W+1:2]
- BTB_IDX_W, 4, log2 of BTB entries (16); index = pc[BTB_IDX_W+1:2]
- BTB_TAG_W, 30-BTB_IDX_W, tag = pc[31:BTB_IDX_W+2]

Ports:
- i_clk  in  1  single clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_if_req  in  1  lookup request for i_if_pc
- i_if_pc  in  `WIDTH  fetch PC; bits [1:0] ignored
- i_if_stall  in  1  hold prediction outputs
- i_flush  in  1  pipeline flush; kill pending/held prediction
- i_upd_valid  in  1  resolved branch from BJP stage
- i_upd_pc  in  `WIDTH  PC of resolved branch
- i_upd_taken  in  1  actual direction
- i_upd_target  in  `WIDTH  actual taken target
- o_bp_valid  out  1  prediction outputs valid
- o_bp_pc  out  `WIDTH  PC the prediction belongs to
- o_bp_deci  out  2  decision to pipeline (BJP treats |deci as predicted-taken)
- o_bp_taken  out  1  predicted taken
- o_bp_target  out  `WIDTH  predicted next fetch PC

Behaviour:
- Reset (i_rst=1 at posedge):
  - All BHT counters become 2'b01 (weakly not-taken).
  - All BTB valid bits become 0.
  - o_bp_valid=0, o_bp_pc=0, o_bp_deci=2'b00, o_bp_taken=0, o_bp_target=0.
  - Reset overrides every other input in the same cycle, and applies mid-operation with no partial state kept.
- Output-register priority per posedge: i_rst > i_flush > i_if_stall > i_if_req.
  - i_flush=1: o_bp_valid<=0. Other outputs are don't-care but keep their previous values.
  - else i_if_stall=1: all outputs hold.
  - else i_if_req=1: compute a prediction for i_if_pc and register it; o_bp_valid<=1.
  - else: o_bp_valid<=0.
- Prediction (computed from table state before this edge's update, i.e. read-before-write):
  - ctr = BHT[idx]
  - hit = BTB valid[idx] & tag match
  - o_bp_taken = ctr[1] & hit
  - o_bp_deci = o_bp_taken ? ctr : 2'b00 (never 00 when taken, never non-00 when not taken)
  - o_bp_target = o_bp_taken ? BTB target : i_if_pc+4. The +4 wraps modulo 2^32: 0xFFFF_FFFC gives 0x0000_0000.
- Update (every posedge with i_upd_valid=1 and i_rst=0; independent of flush/stall):
  - BHT: taken increments the counter, saturating at 2'b11. Not-taken decrements it, saturating at 2'b00.
  - BTB on taken: write valid=1, tag, and i_upd_target at the BTB index, overwriting any alias.
  - BTB on not-taken: unchanged.
- Same-index lookup and update in one cycle: the lookup sees the old value, and the update lands.
- Aliasing: BHT entries have no tag, so PCs differing only above the index share a counter. The BTB tag check prevents a wrong target being used.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then i_if_req=1 with pc=0x100 -> next cycle o_bp_valid=1, o_bp_deci=00, o_bp_taken=0, o_bp_target=0x104.
- Three updates of pc=0x100 taken, target 0x80, then lookup 0x100 -> ctr=11, o_bp_deci=11, o_bp_taken=1, o_bp_target=0x80. A fourth taken update keeps ctr at 11.
- Alias: after training 0x100 taken, lookup pc=0x200 (same BHT index with defaults; BTB tag differs) -> o_bp_taken=0, o_bp_deci=00, target=0x204.
- Same-cycle lookup and update of 0x100 (ctr=01, update taken) -> that prediction shows not-taken. The next lookup shows deci=10, taken=1 (BTB written by the same update).
- Stall then flush: valid prediction held for 2 stall cycles with unchanged outputs. Asserting i_flush together with i_if_stall -> o_bp_valid=0 next cycle.
- Wrap and reset: lookup 0xFFFF_FFFC on a cold table -> target 0x0000_0000. Assert i_rst mid-stream after training -> the next lookup of a trained PC gives deci=00, taken=0.
